// File: rtl/vpu_pkg.sv
// vpu_pkg: shared scheduler states, line record layout and refresh defaults
package vpu_pkg;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT_CLIP,
        EMIT,
        NEXT
    } sched_state_t;
    localparam int LINE_COORD_W = 16;
    typedef struct packed {
        logic [LINE_COORD_W-1:0] x0;
        logic [LINE_COORD_W-1:0] y0;
        logic [LINE_COORD_W-1:0] x1;
        logic [LINE_COORD_W-1:0] y1;
    } line_t;
    localparam int REFRESH_CYCLES_60HZ = 1666667;
endpackage

// File: rtl/refresh_timer.sv
// refresh_timer: free-running period counter with a one-cycle tick on the last count
module refresh_timer
    import vpu_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_60HZ
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int CW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
    logic [CW-1:0] count_q, count_d;
    assign tick_o = count_q == LAST;
    // Wrap to zero after the last count of each period
    always_comb count_d = tick_o ? '0 : count_q + CW'(1);
    // Period counter runs regardless of whether anyone consumes the tick
    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/clip_frame_sched.sv
// clip_frame_sched: per-frame scheduler feeding the line clipper from the line-list memory
module clip_frame_sched
    import vpu_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_60HZ,
    parameter int ADDR_W         = 6,
    parameter int COORD_W        = 16
) (
    input  logic                 clkin_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [ADDR_W:0]      line_count_i,
    output logic                 mem_rd_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    input  logic [4*COORD_W-1:0] mem_rdata_i,
    output logic                 clip_start_o,
    output logic [COORD_W-1:0]   clip_x0_o,
    output logic [COORD_W-1:0]   clip_y0_o,
    output logic [COORD_W-1:0]   clip_x1_o,
    output logic [COORD_W-1:0]   clip_y1_o,
    input  logic                 clip_done_i,
    input  logic                 clip_visible_i,
    input  logic [4*COORD_W-1:0] clip_res_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [4*COORD_W-1:0] out_line_o,
    output logic                 frame_start_o,
    output logic                 frame_done_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int LW = 4 * COORD_W;
    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, idx_inc;
    logic [LW-1:0]     clip_q, clip_d, line_q, line_d;
    logic              overrun_q, overrun_d, tick, last;

    refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
        .clk_i (clkin_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    assign idx_inc     = {1'b0, idx_q} + (ADDR_W + 1)'(1);
    assign last        = cnt_q == '0 || idx_inc == cnt_q;
    assign mem_addr_o  = idx_q;
    assign clip_x0_o   = clip_q[4*COORD_W-1 -: COORD_W];
    assign clip_y0_o   = clip_q[3*COORD_W-1 -: COORD_W];
    assign clip_x1_o   = clip_q[2*COORD_W-1 -: COORD_W];
    assign clip_y1_o   = clip_q[COORD_W-1 -: COORD_W];
    assign out_line_o  = line_q;
    assign out_valid_o = state_q == EMIT;
    assign overrun_o   = overrun_q;
    assign busy_o      = state_q != IDLE;

    // Next state, datapath captures and per-state strobes; an empty list passes FETCH without a read
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        clip_d        = clip_q;
        line_d        = line_q;
        overrun_d     = overrun_q | (tick && state_q != IDLE);
        mem_rd_o      = 1'b0;
        clip_start_o  = 1'b0;
        frame_start_o = 1'b0;
        frame_done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = tick && enable_i ? line_count_i : cnt_q;
                state_d = tick && enable_i ? FETCH : IDLE;
            end
            FETCH: begin
                frame_start_o = idx_q == '0;
                mem_rd_o      = cnt_q != '0;
                state_d       = cnt_q == '0 ? NEXT : LOAD;
            end
            LOAD: begin
                clip_d  = mem_rdata_i;
                state_d = ISSUE;
            end
            ISSUE: begin
                clip_start_o = 1'b1;
                state_d      = WAIT_CLIP;
            end
            WAIT_CLIP: begin
                line_d  = clip_done_i && clip_visible_i ? clip_res_i : line_q;
                state_d = !clip_done_i ? WAIT_CLIP : clip_visible_i ? EMIT : NEXT;
            end
            EMIT: state_d = out_ready_i ? NEXT : EMIT;
            NEXT: begin
                frame_done_o = last;
                idx_d        = last ? '0 : idx_inc[ADDR_W-1:0];
                state_d      = last ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress
    always_ff @(posedge clkin_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            clip_q    <= '0;
            line_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            clip_q    <= clip_d;
            line_q    <= line_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_clip_frame_sched.sv
// tb_clip_frame_sched: table-driven frame scenarios plus stall, reset, enable and overrun sequences
module tb_clip_frame_sched;
    localparam int AW = 6;
    localparam logic [63:0] L0  = {16'd0, 16'd0, 16'd10, 16'd10};
    localparam logic [63:0] L1  = {16'd5, 16'd5, 16'd50, 16'd50};
    localparam logic [63:0] L2  = {16'd100, 16'd0, 16'd200, 16'd0};
    localparam logic [63:0] L2C = {16'd63, 16'd0, 16'd63, 16'd0};
    localparam logic [63:0] L3  = {16'd1, 16'd2, 16'd3, 16'd4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, enable = 1'b0, out_ready = 1'b1;
    logic [AW:0] line_count = '0;
    logic mem_rd, clip_start, out_valid, frame_start, frame_done, overrun, busy;
    logic [AW-1:0] mem_addr;
    logic [15:0] cx0, cy0, cx1, cy1;
    logic [63:0] mem_rdata = '0, clip_res = '0, out_line;
    logic clip_done = 1'b0, clip_visible = 1'b0;

    logic enable_b = 1'b0;
    logic [AW:0] line_count_b = '0;
    logic mem_rd_b, clip_start_b, out_valid_b, frame_start_b, frame_done_b, overrun_b, busy_b;
    logic [AW-1:0] mem_addr_b;
    logic [15:0] bx0, by0, bx1, by1;
    logic [63:0] mem_rdata_b = '0, clip_res_b = '0, out_line_b;
    logic clip_done_b = 1'b0, clip_visible_b = 1'b0;

    clip_frame_sched #(.REFRESH_CYCLES(20), .ADDR_W(AW), .COORD_W(16)) dut (
        .clkin_i(clk), .rst_i(rst), .enable_i(enable), .line_count_i(line_count),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .clip_start_o(clip_start), .clip_x0_o(cx0), .clip_y0_o(cy0), .clip_x1_o(cx1), .clip_y1_o(cy1),
        .clip_done_i(clip_done), .clip_visible_i(clip_visible), .clip_res_i(clip_res),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_line_o(out_line),
        .frame_start_o(frame_start), .frame_done_o(frame_done), .overrun_o(overrun), .busy_o(busy)
    );

    clip_frame_sched #(.REFRESH_CYCLES(8), .ADDR_W(AW), .COORD_W(16)) dut_b (
        .clkin_i(clk), .rst_i(rst), .enable_i(enable_b), .line_count_i(line_count_b),
        .mem_rd_o(mem_rd_b), .mem_addr_o(mem_addr_b), .mem_rdata_i(mem_rdata_b),
        .clip_start_o(clip_start_b), .clip_x0_o(bx0), .clip_y0_o(by0), .clip_x1_o(bx1), .clip_y1_o(by1),
        .clip_done_i(clip_done_b), .clip_visible_i(clip_visible_b), .clip_res_i(clip_res_b),
        .out_valid_o(out_valid_b), .out_ready_i(1'b1), .out_line_o(out_line_b),
        .frame_start_o(frame_start_b), .frame_done_o(frame_done_b), .overrun_o(overrun_b), .busy_o(busy_b)
    );

    logic [63:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = L0; mem[1] = L1; mem[2] = L2; mem[3] = L3;
    end

    function automatic logic [63:0] clipf(input logic [63:0] l);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = l[i*16 +: 16] > 16'd63 ? 16'd63 : l[i*16 +: 16];
        return r;
    endfunction

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
    always @(posedge clk) if (mem_rd_b) mem_rdata_b <= mem[mem_addr_b];

    int lat = 3;
    logic [15:0] drop_x0 = 16'hFFFF;
    int ccnt = 0, ccnt_b = 0;
    always @(posedge clk) begin
        clip_done <= 1'b0;
        if (clip_start) ccnt <= lat - 1;
        else if (ccnt > 1) ccnt <= ccnt - 1;
        else if (ccnt == 1) begin
            ccnt <= 0;
            clip_done <= 1'b1;
            clip_visible <= cx0 != drop_x0;
            clip_res <= clipf({cx0, cy0, cx1, cy1});
        end
    end
    always @(posedge clk) begin
        clip_done_b <= 1'b0;
        if (clip_start_b) ccnt_b <= 9;
        else if (ccnt_b > 1) ccnt_b <= ccnt_b - 1;
        else if (ccnt_b == 1) begin
            ccnt_b <= 0;
            clip_done_b <= 1'b1;
            clip_visible_b <= 1'b1;
            clip_res_b <= clipf({bx0, by0, bx1, by1});
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    logic [AW-1:0] addr_log[$];
    logic [63:0] out_log[$], out_log_b[$];
    int n_start, n_fs, n_fd, fs_cyc, fd_cyc, n_fs_b, n_fd_b, ov_cyc_b;
    always @(negedge clk) if (!rst) begin
        if (mem_rd) addr_log.push_back(mem_addr);
        if (out_valid && out_ready) out_log.push_back(out_line);
        if (clip_start) n_start = n_start + 1;
        if (frame_start) begin n_fs = n_fs + 1; fs_cyc = cyc; end
        if (frame_done) begin n_fd = n_fd + 1; fd_cyc = cyc; end
        if (out_valid_b) out_log_b.push_back(out_line_b);
        if (frame_start_b) n_fs_b = n_fs_b + 1;
        if (frame_done_b) n_fd_b = n_fd_b + 1;
        if (overrun_b && ov_cyc_b < 0) ov_cyc_b = cyc;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete(); out_log.delete(); out_log_b.delete();
        n_start = 0; n_fs = 0; n_fd = 0; fs_cyc = -1; fd_cyc = -1;
        n_fs_b = 0; n_fd_b = 0; ov_cyc_b = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_fd(input string nm, input int lim);
        for (int k = 0; k < lim && n_fd == 0; k++) @(negedge clk);
        chk(nm, 64'(n_fd > 0), 64'd1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ctl"}, {busy, out_valid, mem_rd, clip_start, frame_start, frame_done, overrun}, 0);
        chk({nm, "_data"}, {cx0, cy0, cx1, cy1} | out_line | 64'(mem_addr), 0);
    endtask

    typedef struct {
        int cnt; logic [15:0] drop; int n_rd; int n_out; int ovr; int fd;
        logic [63:0] o0, o1, o2;
    } vec_t;
    vec_t vecs[5];

    initial begin
        logic [63:0] exp_o[3];
        int bad, na;
        vecs[0] = '{0, 16'hFFFF, 0, 0, 0, 21, 0, 0, 0};
        vecs[1] = '{3, 16'hFFFF, 3, 3, 1, 43, L0, L1, L2C};
        vecs[2] = '{3, 16'd5, 3, 2, 1, 42, L0, L2C, 0};
        vecs[3] = '{1, 16'hFFFF, 1, 1, 0, 27, L0, 0, 0};
        vecs[4] = '{2, 16'd0, 2, 1, 0, 34, L1, 0, 0};

        do_reset();
        @(negedge clk);
        chk_idle_outputs("reset_state");

        for (int v = 0; v < 5; v++) begin
            do_reset();
            lat = 3; drop_x0 = vecs[v].drop; out_ready = 1'b1;
            line_count = (AW + 1)'(vecs[v].cnt); enable = 1'b1;
            wait_fd($sformatf("v%0d_fd_seen", v), 200);
            enable = 1'b0;
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_fs_cyc", v), 64'(fs_cyc), 64'd20);
            chk($sformatf("v%0d_fd_cyc", v), 64'(fd_cyc), 64'(vecs[v].fd));
            chk($sformatf("v%0d_n_fs_fd", v), {32'(n_fs), 32'(n_fd)}, {32'd1, 32'd1});
            chk($sformatf("v%0d_n_rd", v), 64'(addr_log.size()), 64'(vecs[v].n_rd));
            chk($sformatf("v%0d_n_start", v), 64'(n_start), 64'(vecs[v].n_rd));
            if (addr_log.size() == vecs[v].n_rd)
                for (int i = 0; i < vecs[v].n_rd; i++) chk($sformatf("v%0d_addr%0d", v, i), 64'(addr_log[i]), 64'(i));
            chk($sformatf("v%0d_n_out", v), 64'(out_log.size()), 64'(vecs[v].n_out));
            exp_o[0] = vecs[v].o0; exp_o[1] = vecs[v].o1; exp_o[2] = vecs[v].o2;
            if (out_log.size() == vecs[v].n_out)
                for (int i = 0; i < vecs[v].n_out; i++) chk($sformatf("v%0d_out%0d", v, i), out_log[i], exp_o[i]);
            chk($sformatf("v%0d_overrun", v), 64'(overrun), 64'(vecs[v].ovr));
            chk($sformatf("v%0d_busy_end", v), 64'(busy), 64'd0);
        end

        do_reset();
        lat = 3; drop_x0 = 16'hFFFF; out_ready = 1'b0; line_count = 7'd3; enable = 1'b1;
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        line_count = 7'd1;
        na = addr_log.size();
        chk("stall_rd_before", 64'(na), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("stall_line%0d", i), out_line, L0);
            chk($sformatf("stall_no_rd%0d", i), 64'(addr_log.size()), 64'(na));
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_valid_drop", 64'(out_valid), 64'd0);
        wait_fd("stall_fd_seen", 200);
        enable = 1'b0;
        chk("stall_n_out", 64'(out_log.size()), 64'd3);
        if (out_log.size() == 3) chk("stall_outs", {out_log[0] ^ L0, out_log[1] ^ L1}, {64'd0, 64'd0});

        do_reset();
        lat = 6; out_ready = 1'b1; line_count = 7'd3; enable = 1'b1;
        for (int k = 0; k < 100 && n_start < 2; k++) @(negedge clk);
        chk("rst_reached_line1", 64'(n_start), 64'd2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        clear_logs();
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy || out_valid || clip_start || mem_rd || frame_done) bad++;
            @(negedge clk);
        end
        chk("late_done_ignored", 64'(bad), 64'd0);
        for (int k = 0; k < 40 && n_fs == 0; k++) @(negedge clk);
        enable = 1'b0;
        chk("restart_fs_cyc", 64'(fs_cyc), 64'd20);
        @(negedge clk);
        chk("restart_addr0", addr_log.size() > 0 ? 64'(addr_log[0]) : 64'hDEAD, 64'd0);
        wait_fd("restart_fd_seen", 200);
        chk("restart_n_out", 64'(out_log.size()), 64'd3);

        do_reset();
        line_count = 7'd1; enable = 1'b0;
        repeat (45) @(negedge clk);
        chk("disabled_no_frame", {32'(n_fs), 31'd0, busy}, 0);
        chk("disabled_no_overrun", 64'(overrun), 64'd0);

        do_reset();
        line_count_b = 7'd4; enable_b = 1'b1;
        for (int k = 0; k < 50 && n_fs_b == 0; k++) @(negedge clk);
        enable_b = 1'b0;
        line_count_b = 7'd1;
        chk("ovr_clear_at_start", 64'(overrun_b), 64'd0);
        for (int k = 0; k < 400 && n_fd_b == 0; k++) @(negedge clk);
        chk("ovr_fd_seen", 64'(n_fd_b), 64'd1);
        chk("ovr_first_cyc", 64'(ov_cyc_b), 64'd16);
        chk("ovr_n_out", 64'(out_log_b.size()), 64'd4);
        if (out_log_b.size() == 4)
            chk("ovr_outs", {out_log_b[0] ^ L0, out_log_b[1] ^ L1, out_log_b[2] ^ L2C, out_log_b[3] ^ L3}, 0);
        repeat (20) @(negedge clk);
        chk("ovr_sticky", {31'd0, overrun_b, 31'(n_fs_b), busy_b}, {31'd0, 1'b1, 31'd1, 1'b0});
        do_reset();
        @(negedge clk);
        chk("ovr_rst_clears", 64'(overrun_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
